// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the IF stage and decode
package fetch_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, DRAIN} fetch_state_t;
   localparam logic [31:0] NOP        = 32'h0000_0000;
   localparam logic [31:0] EXC_VECTOR = 32'h0000_0080;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch buffer of {pc, inst} words; clear beats push and pop
module fetch_fifo import fetch_pkg::*; #(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clear,
   input  fetch_entry_t             din,
   output logic [$clog2(DEPTH):0]   count,
   output fetch_entry_t             head
);
   localparam int AW = $clog2(DEPTH);
   fetch_entry_t mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   assign head = mem[rd_ptr];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
         count  <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   always_ff @(posedge clk)
      if (push && !clear) mem[wr_ptr] <= din;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage - fetch PC, single-outstanding imem req/ack,
// prefetch FIFO and the IF/ID register consumed by decode
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR = fetch_pkg::EXC_VECTOR,
   parameter int          DEPTH      = 2,
   parameter logic [31:0] NOP        = fetch_pkg::NOP
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        hold_pc,
   input  logic        hold_if,
   input  logic        br,
   input  logic [31:0] pc_branch,
   input  logic        exception,
   output logic        flush_id,
   output logic [31:0] pc,
   output logic [31:0] inst_out,
   output logic        inst_valid
);
   import fetch_pkg::*;
   localparam int CW = $clog2(DEPTH) + 1;
   fetch_state_t state;
   fetch_entry_t head, din;
   logic [31:0] fetch_pc, target;
   logic [CW-1:0] count;
   logic redirect, hold, push, pop;
   assign redirect  = exception | br;
   assign hold      = hold_if | hold_pc;
   assign target    = (exception ? EXC_VECTOR : pc_branch) & ~32'h3;
   assign push      = state == WAIT && imem_ack && !redirect;
   assign pop       = !redirect && !hold && count != '0;
   assign din       = {fetch_pc, imem_rdata};
   assign imem_addr = fetch_pc;
   // a redirect suppresses the request so the stale address never reaches memory
   assign imem_req  = !rst && state == IDLE && !redirect && count != CW'(DEPTH);
   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .clear(redirect),
      .din(din), .count(count), .head(head)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC & ~32'h3;
      end else if (redirect) begin
         // a request still in flight must have its ack discarded later
         state    <= (state != IDLE && !imem_ack) ? DRAIN : IDLE;
         fetch_pc <= target;
      end else begin
         state    <= imem_req ? WAIT : (state != IDLE && imem_ack) ? IDLE : state;
         fetch_pc <= push ? fetch_pc + 32'd4 : fetch_pc;
      end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pc         <= '0;
         inst_out   <= NOP;
         inst_valid <= 1'b0;
         flush_id   <= 1'b0;
      end else begin
         flush_id <= redirect;
         if (redirect || !hold) begin
            pc         <= pop ? head.pc : pc;
            inst_out   <= pop ? head.inst : NOP;
            inst_valid <= pop;
         end
      end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: cycle table plus scoreboard of fetched words for fetch_unit
module tb_fetch_unit;
   import fetch_pkg::*;
   logic clk = 1'b0, rst = 1'b1;
   logic imem_req, imem_ack = 1'b0, hold_pc = 1'b0, hold_if = 1'b0;
   logic br = 1'b0, exception = 1'b0, flush_id, inst_valid;
   logic [31:0] imem_addr, imem_rdata = '0, pc_branch = '0, pc, inst_out;

   fetch_unit dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .hold_pc(hold_pc),
      .hold_if(hold_if), .br(br), .pc_branch(pc_branch), .exception(exception),
      .flush_id(flush_id), .pc(pc), .inst_out(inst_out), .inst_valid(inst_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic h, b, e;
      logic [31:0] tgt;
      logic req;
      logic [31:0] addr;
      logic flush;
   } vec_t;

   vec_t tbl [23];
   fetch_entry_t exp_q [$];
   fetch_entry_t exp_e;
   logic exp_v, pend, stale, r;
   logic [31:0] pend_addr, a;
   int pend_due, cyc, mem_lat, errors, checks;

   function automatic logic [31:0] mem_word(input logic [31:0] ad);
      return ad == 32'h0 ? 32'h2001_0005 : ad == 32'h4 ? 32'h2002_0007 : (32'hC000_0000 | ad);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_e = '{pc: 32'h0, inst: NOP};
      exp_v = 1'b0;
      pend  = 1'b0;
      stale = 1'b0;
   endtask

   // one clock cycle: drive at negedge, sample request, predict IF/ID, check after the edge
   task automatic step(input logic h, input logic b, input logic [31:0] tgt, input logic e,
                       input logic stray, output logic req_s, output logic [31:0] addr_s);
      logic ack_now, redir;
      hold_if = h; hold_pc = h; br = b; pc_branch = tgt; exception = e;
      ack_now = pend && pend_due == cyc;
      imem_ack = ack_now | stray;
      imem_rdata = stray ? 32'hDEAD_BEEF : mem_word(pend_addr);
      #1;
      req_s = imem_req;
      addr_s = imem_addr;
      redir = b | e;
      if (redir) begin
         exp_q.delete();
         exp_e.inst = NOP;
         exp_v = 1'b0;
      end else if (!h) begin
         if (exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            exp_v = 1'b1;
         end else begin
            exp_e.inst = NOP;
            exp_v = 1'b0;
         end
      end
      if (ack_now) begin
         if (!stale && !redir) exp_q.push_back('{pc: pend_addr, inst: mem_word(pend_addr)});
         stale = 1'b0;
         pend = 1'b0;
      end else if (redir && pend) stale = 1'b1;
      if (req_s) begin
         pend = 1'b1;
         pend_addr = addr_s;
         pend_due = cyc + mem_lat;
      end
      @(posedge clk);
      cyc++;
      #1;
      chk($sformatf("c%0d_valid", cyc), 32'(inst_valid), 32'(exp_v));
      chk($sformatf("c%0d_inst", cyc), inst_out, exp_e.inst);
      if (exp_v) chk($sformatf("c%0d_pc", cyc), pc, exp_e.pc);
      chk($sformatf("c%0d_flush", cyc), 32'(flush_id), 32'(redir));
      imem_ack = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int unsigned rc [9] = '{0, 2, 4, 6, 13, 15, 17, 20, 22};
      logic [31:0] ra [9] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h100, 32'h104, 32'h80, 32'h84};
      errors = 0; checks = 0; cyc = 0; mem_lat = 1;
      model_reset();
      for (int i = 0; i < 23; i++)
         tbl[i] = '{h: (i >= 6 && i <= 11), b: 1'b0, e: 1'b0, tgt: 32'h0, req: 1'b0, addr: 32'h0, flush: 1'b0};
      for (int i = 0; i < 9; i++) begin
         tbl[rc[i]].req = 1'b1;
         tbl[rc[i]].addr = ra[i];
      end
      tbl[14].b = 1'b1; tbl[14].tgt = 32'h100; tbl[14].flush = 1'b1;
      tbl[19].b = 1'b1; tbl[19].e = 1'b1; tbl[19].tgt = 32'h40; tbl[19].flush = 1'b1;

      @(posedge clk); @(posedge clk); @(negedge clk);
      chk("rst_req", 32'(imem_req), 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_flush", 32'(flush_id), 32'h0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_inst", inst_out, NOP);
      chk("rst_valid", 32'(inst_valid), 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 23; i++) begin
         step(tbl[i].h, tbl[i].b, tbl[i].tgt, tbl[i].e, 1'b0, r, a);
         chk($sformatf("row%0d_req", i), 32'(r), 32'(tbl[i].req));
         if (tbl[i].req) chk($sformatf("row%0d_addr", i), a, tbl[i].addr);
         chk($sformatf("row%0d_flush", i), 32'(flush_id), 32'(tbl[i].flush));
      end

      // branch while waiting on a slow memory: the late ack must be dropped
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, r, a);
      chk("a_ack_req", 32'(r), 32'h0);
      mem_lat = 2;
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, r, a);
      chk("a_req", 32'(r), 32'h1);
      chk("a_addr", a, 32'h88);
      step(1'b0, 1'b1, 32'h43, 1'b0, 1'b0, r, a);
      chk("a_br_req", 32'(r), 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, r, a);
      chk("a_stale_req", 32'(r), 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, r, a);
      chk("a_tgt_req", 32'(r), 32'h1);
      chk("a_tgt_addr", a, 32'h40);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, r, a);
      chk("a_tgt_pc", pc, 32'h40);
      chk("a_tgt_inst", inst_out, 32'hC000_0040);

      // asynchronous reset while a request is outstanding
      r = 1'b0;
      for (int k = 0; k < 8 && !r; k++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, r, a);
      chk("b_req_seen", 32'(r), 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("b_rst_req", 32'(imem_req), 32'h0);
      chk("b_rst_addr", imem_addr, 32'h0);
      chk("b_rst_flush", 32'(flush_id), 32'h0);
      chk("b_rst_pc", pc, 32'h0);
      chk("b_rst_inst", inst_out, NOP);
      chk("b_rst_valid", 32'(inst_valid), 32'h0);
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      model_reset();
      mem_lat = 1;
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, r, a);
      chk("b_first_req", 32'(r), 32'h1);
      chk("b_first_addr", a, 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, r, a);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, r, a);
      chk("b_first_inst", inst_out, 32'h2001_0005);
      chk("b_first_valid", 32'(inst_valid), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
